// File: rtl/obstacle_scheduler_if.sv
// ---------------------------------------------------------------------------
// obstacle_scheduler_if
//   Frame-control and obstacle-slot bundle between the game controller
//   (master) and the obstacle scheduler (slave).
//
//   tick        frame tick, one-cycle pulse per video frame
//   run         game running; low while crashed / game over
//   restart     one-cycle pulse starting a new game
//   speed[3:0]  scroll distance per frame in pixels
//   slot_active per-slot valid flags, bit i = slot i
//   slot_x      packed 10-bit x positions, slot i = [10i+9:10i]
//   slot_type   packed 2-bit types, slot i = [2i+1:2i]
//               00 small cactus, 01 large cactus, 10 low bird, 11 high bird
//   spawn       one-cycle pulse when an obstacle is placed
//   overrun     sticky: a tick arrived while a frame was still in flight
// ---------------------------------------------------------------------------
interface obstacle_scheduler_if;
  logic        tick;
  logic        run;
  logic        restart;
  logic [3:0]  speed;
  logic [2:0]  slot_active;
  logic [29:0] slot_x;
  logic [5:0]  slot_type;
  logic        spawn;
  logic        overrun;

  modport master (
    output tick, run, restart, speed,
    input  slot_active, slot_x, slot_type, spawn, overrun
  );

  modport slave (
    input  tick, run, restart, speed,
    output slot_active, slot_x, slot_type, spawn, overrun
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// ---------------------------------------------------------------------------
// obstacle_scheduler
//   Keeps up to three scrolling obstacles for an endless-runner game. Each
//   accepted frame tick walks IDLE -> MOVE -> SPAWN -> IDLE:
//     entering MOVE : slots scroll left by speed, expired slots are freed,
//                     the gap accumulator grows, the LFSR steps once;
//     entering SPAWN: if the gap has reached the threshold and a slot is
//                     free, the lowest free slot gets a new obstacle at the
//                     right screen edge and spawn pulses during SPAWN.
//   Tick at cycle N: moved positions visible in N+1, spawn pulse in N+2,
//   everything settled from N+3.
//
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   obstacle_scheduler_if.slave (frame control in, slot state out)
// ---------------------------------------------------------------------------
module obstacle_scheduler #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned MIN_GAP    = 200,
  parameter int unsigned BIRD_SPEED = 6,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic rstn,
  obstacle_scheduler_if.slave bus
);

  localparam int          NSLOT       = 3;
  localparam logic [9:0]  SPAWN_X     = 10'(SCREEN_W);
  localparam logic [10:0] THRESH_BASE = 11'(MIN_GAP);
  localparam logic [4:0]  BIRD_MIN    = 5'(BIRD_SPEED);
  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

  state_t      state_q, state_d;
  logic        enter_move, enter_spawn, drop_tick;

  logic [2:0]  active_q;
  logic [9:0]  x_q    [NSLOT];
  logic [1:0]  type_q [NSLOT];
  logic [9:0]  gap_q;
  logic [10:0] thresh_q;
  logic [15:0] lfsr_q;
  logic        spawn_q;
  logic        overrun_q;

  logic [2:0]  free_vec, free_sel;
  logic        spawn_ok;
  logic        bird_ok;
  logic [1:0]  new_type;
  logic [10:0] gap_sum;
  logic [9:0]  gap_next;
  logic [15:0] lfsr_next;

  // -------------------------------------------------------------------------
  // FSM next state and per-edge strobes
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    enter_move  = 1'b0;
    enter_spawn = 1'b0;
    drop_tick   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // With run low the tick is simply not accepted; nothing moves.
        if (bus.tick && bus.run) begin
          state_d    = MOVE;
          enter_move = 1'b1;
        end
      end
      MOVE: begin
        state_d     = SPAWN;
        enter_spawn = 1'b1;
        drop_tick   = bus.tick;
      end
      SPAWN: begin
        state_d   = IDLE;
        drop_tick = bus.tick;
      end
      default: state_d = IDLE;
    endcase
    if (bus.restart) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath helpers
  // -------------------------------------------------------------------------
  // Isolate the lowest set bit of the free mask: lowest-index free slot.
  assign free_vec = ~active_q;
  assign free_sel = free_vec & (~free_vec + 3'd1);

  assign spawn_ok = enter_spawn && (|free_vec) && ({1'b0, gap_q} >= thresh_q);

  // Too slow for birds: force the type into the cactus half.
  assign bird_ok  = ({1'b0, bus.speed} >= BIRD_MIN);
  assign new_type = {lfsr_q[9] & bird_ok, lfsr_q[8]};

  assign gap_sum  = {1'b0, gap_q} + {7'd0, bus.speed};
  assign gap_next = gap_sum[10] ? 10'h3FF : gap_sum[9:0];

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q  <= '0;
      // NOTE: the slot arrays are three small flop banks, not a RAM, so they
      // are cleared by reset like any other register.
      for (int i = 0; i < NSLOT; i++) begin
        x_q[i]    <= '0;
        type_q[i] <= '0;
      end
      gap_q     <= '0;
      thresh_q  <= THRESH_BASE;
      lfsr_q    <= LFSR_SEED;
      spawn_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (bus.restart) begin
      // New game: clear the field but let the LFSR keep its sequence so
      // consecutive games do not replay the same obstacles.
      active_q  <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        x_q[i]    <= '0;
        type_q[i] <= '0;
      end
      gap_q     <= '0;
      thresh_q  <= THRESH_BASE;
      spawn_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees
      // the pre-edge value regardless of statement order.
      spawn_q <= 1'b0;
      if (drop_tick) begin
        overrun_q <= 1'b1;
      end

      if (enter_move) begin
        lfsr_q <= lfsr_next;
        gap_q  <= gap_next;
        for (int i = 0; i < NSLOT; i++) begin
          if (active_q[i]) begin
            if (x_q[i] >= {6'd0, bus.speed}) begin
              x_q[i] <= x_q[i] - {6'd0, bus.speed};
            end else begin
              // Scrolled off the left edge: free the slot, read back as 0.
              x_q[i]      <= '0;
              type_q[i]   <= '0;
              active_q[i] <= 1'b0;
            end
          end
        end
      end

      if (spawn_ok) begin
        for (int i = 0; i < NSLOT; i++) begin
          if (free_sel[i]) begin
            active_q[i] <= 1'b1;
            x_q[i]      <= SPAWN_X;
            type_q[i]   <= new_type;
          end
        end
        gap_q    <= '0;
        thresh_q <= THRESH_BASE + {3'd0, lfsr_q[7:0]};
        spawn_q  <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // -------------------------------------------------------------------------
  assign bus.slot_active = active_q;
  assign bus.spawn       = spawn_q;
  assign bus.overrun     = overrun_q;

  for (genvar g = 0; g < NSLOT; g++) begin : g_pack
    assign bus.slot_x[g*10 +: 10]  = x_q[g];
    assign bus.slot_type[g*2 +: 2] = type_q[g];
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// ---------------------------------------------------------------------------
// tb_obstacle_scheduler
//   Directed bench for obstacle_scheduler. The main instance (defaults) is
//   shadowed by a frame-level model compared on every falling edge, plus
//   literal checks of hand-derived values. A second instance with
//   SCREEN_W=1000, MIN_GAP=0 is checked with literal expectations only
//   (first LFSR step from the seed, blocked spawn when all slots are full).
// ---------------------------------------------------------------------------
module tb_obstacle_scheduler;

  localparam int SCREEN_W   = 640;
  localparam int MIN_GAP    = 200;
  localparam int BIRD_SPEED = 6;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  obstacle_scheduler_if bus ();
  obstacle_scheduler_if bus2 ();

  obstacle_scheduler dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  obstacle_scheduler #(
    .SCREEN_W (1000),
    .MIN_GAP  (0)
  ) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Frame-level model of the main instance. A whole frame (scroll, gap,
  // LFSR, spawn decision) is computed at the moment the tick is accepted;
  // the spawn result is revealed one cycle later.
  // -------------------------------------------------------------------------
  bit          m_act [3];
  int          m_x   [3];
  int          m_ty  [3];
  int          m_gap, m_thresh;
  logic [15:0] m_lfsr;
  bit          m_spawn, m_ovr;
  int          m_busy;        // cycles of the current frame already spent
  bit          p_go;
  int          p_slot, p_type, p_thresh;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = 0;
      m_ty[i]  = 0;
    end
    m_gap    = 0;
    m_thresh = MIN_GAP;
    m_spawn  = 1'b0;
    m_ovr    = 1'b0;
    m_busy   = 0;
    p_go     = 1'b0;
  endtask

  task automatic model_frame(input int sp);
    m_lfsr = lfsr_step(m_lfsr);
    for (int i = 0; i < 3; i++) begin
      if (m_act[i]) begin
        if (m_x[i] >= sp) begin
          m_x[i] = m_x[i] - sp;
        end else begin
          m_x[i] = 0; m_ty[i] = 0; m_act[i] = 1'b0;
        end
      end
    end
    m_gap = (m_gap + sp > 1023) ? 1023 : m_gap + sp;
    p_go = 1'b0;
    if (m_gap >= m_thresh) begin
      for (int i = 0; i < 3; i++) begin
        if (!m_act[i] && !p_go) begin
          p_go = 1'b1; p_slot = i;
        end
      end
    end
    p_type   = int'(m_lfsr[9:8]);
    if (sp < BIRD_SPEED) p_type = p_type % 2;
    p_thresh = MIN_GAP + int'(m_lfsr[7:0]);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_clear();
      m_lfsr = 16'hACE1;
    end else if (bus.restart) begin
      model_clear();
    end else begin
      m_spawn = 1'b0;
      if (m_busy != 0 && bus.tick) m_ovr = 1'b1;
      if (m_busy == 1) begin
        if (p_go) begin
          m_act[p_slot] = 1'b1;
          m_x[p_slot]   = SCREEN_W;
          m_ty[p_slot]  = p_type;
          m_gap         = 0;
          m_thresh      = p_thresh;
          m_spawn       = 1'b1;
        end
        m_busy = 2;
      end else if (m_busy == 2) begin
        m_busy = 0;
      end else if (bus.tick && bus.run) begin
        model_frame(int'(bus.speed));
        m_busy = 1;
      end
    end
  end

  function automatic logic [63:0] model_vec();
    logic [2:0]  a;
    logic [29:0] x;
    logic [5:0]  t;
    for (int i = 0; i < 3; i++) begin
      a[i]          = m_act[i];
      x[i*10 +: 10] = 10'(m_x[i]);
      t[i*2 +: 2]   = 2'(m_ty[i]);
    end
    return {23'd0, a, x, t, m_spawn, m_ovr};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {23'd0, bus.slot_active, bus.slot_x, bus.slot_type, bus.spawn, bus.overrun};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) check("cycle_outputs", dut_vec(), model_vec());
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers. All drives happen 1 ns after a rising edge.
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [2:0]  mv_act, sp_act;
  logic [29:0] mv_x, sp_x;
  logic [5:0]  mv_ty, sp_ty;
  logic        sp_spawn;

  // One 3-cycle frame: tick, snapshot in MOVE, snapshot in SPAWN.
  task automatic run_frame(input bit second);
    if (second) bus2.tick = 1'b1; else bus.tick = 1'b1;
    step(1);
    bus.tick  = 1'b0;
    bus2.tick = 1'b0;
    @(negedge clk);
    mv_act = second ? bus2.slot_active : bus.slot_active;
    mv_x   = second ? bus2.slot_x      : bus.slot_x;
    mv_ty  = second ? bus2.slot_type   : bus.slot_type;
    step(1);
    @(negedge clk);
    sp_spawn = second ? bus2.spawn       : bus.spawn;
    sp_act   = second ? bus2.slot_active : bus.slot_active;
    sp_x     = second ? bus2.slot_x      : bus.slot_x;
    sp_ty    = second ? bus2.slot_type   : bus.slot_type;
    step(1);
  endtask

  // Index of the slot just placed at x == edge, or 7 if none.
  function automatic int new_slot(input int edge_x);
    int idx = 7;
    for (int i = 0; i < 3; i++) begin
      if (sp_act[i] && int'(sp_x[i*10 +: 10]) == edge_x && idx == 7) idx = i;
    end
    return idx;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first_spawn, idx, spawns2, fourth_frame, fourth_slot;
    bit seen_full;
    logic [3:0] type_seen;

    bus.tick = 1'b0;  bus.run = 1'b0;  bus.restart = 1'b0;  bus.speed = 4'd0;
    bus2.tick = 1'b0; bus2.run = 1'b0; bus2.restart = 1'b0; bus2.speed = 4'd0;

    // Reset state
    step(2);
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_outputs", dut_vec(), 64'd0);
    step(1);
    rstn = 1'b1;
    step(2);

    // First spawn after 20 ticks at speed 10, ticks 100 cycles apart
    bus.run   = 1'b1;
    bus.speed = 4'd10;
    for (int k = 1; k <= 20; k++) begin
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
      if (k == 20) begin
        @(negedge clk);
        check("t20_move_no_spawn", bus.spawn, 0);
        step(1);
        @(negedge clk);
        check("t20_spawn_pulse", bus.spawn, 1);
        check("t20_slot_active", bus.slot_active, 3'b001);
        check("t20_slot0_x", bus.slot_x[9:0], 640);
        step(1);
        @(negedge clk);
        check("spawn_one_cycle", bus.spawn, 0);
      end else if (k == 19) begin
        repeat (3) @(negedge clk);
        check("t19_no_spawn", bus.slot_active, 3'b000);
      end
      step(96);
    end

    // speed 0 freezes positions and gap; ticks with run low are ignored
    bus.speed = 4'd0;
    for (int k = 0; k < 3; k++) run_frame(1'b0);
    check("speed0_x_held", sp_x[9:0], 640);
    check("speed0_no_spawn", sp_spawn, 0);
    bus.speed = 4'd10;
    bus.run   = 1'b0;
    bus.tick  = 1'b1;
    step(1);
    bus.tick  = 1'b0;
    step(3);
    check("run_low_x_held", bus.slot_x[9:0], 640);
    check("run_low_no_overrun", bus.overrun, 0);
    bus.run = 1'b1;

    // Slot expiry: 640 - 42*15 = 10, then -5 = 5, then 5 < 10 frees it
    bus.speed = 4'd15;
    for (int k = 0; k < 42; k++) run_frame(1'b0);
    check("expire_x10", mv_x[9:0], 10);
    bus.speed = 4'd5;
    run_frame(1'b0);
    check("expire_x5", mv_x[9:0], 5);
    bus.speed = 4'd10;
    run_frame(1'b0);
    check("expire_active_bit", mv_act[0], 0);
    check("expire_x0", mv_x[9:0], 0);
    check("expire_type0", mv_ty[1:0], 0);

    // Tick during MOVE: dropped, overrun set and sticky
    bus.tick = 1'b1;
    step(2);
    bus.tick = 1'b0;
    step(3);
    check("overrun_set", bus.overrun, 1);
    run_frame(1'b0);
    run_frame(1'b0);
    check("overrun_sticky", bus.overrun, 1);

    // Restart arriving in MOVE wins over the frame in flight
    bus.tick = 1'b1;
    step(1);
    bus.tick    = 1'b0;
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    @(negedge clk);
    check("restart_clears", dut_vec(), 64'd0);
    step(1);

    // speed 3: cacti only
    bus.speed = 4'd3;
    cnt = 0;
    for (int f = 0; f < 6000 && cnt < 30; f++) begin
      run_frame(1'b0);
      if (sp_spawn) begin
        idx = new_slot(SCREEN_W);
        check("slow_spawn_found", (idx < 3), 1);
        if (idx < 3) check("slow_type_is_cactus", sp_ty[idx*2 + 1], 0);
        cnt++;
      end
    end
    check("slow_spawn_count", cnt, 30);

    // speed 8: all four types appear
    bus.speed = 4'd8;
    cnt = 0;
    type_seen = 4'b0000;
    for (int f = 0; f < 6000 && cnt < 60; f++) begin
      run_frame(1'b0);
      if (sp_spawn) begin
        idx = new_slot(SCREEN_W);
        if (idx < 3) type_seen[sp_ty[idx*2 +: 2]] = 1'b1;
        cnt++;
      end
    end
    check("fast_spawn_count", cnt, 60);
    check("fast_all_types", type_seen, 4'b1111);

    // Asynchronous reset while in MOVE
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    check("async_reset_zero", dut_vec(), 64'd0);
    step(1);
    rstn = 1'b1;
    step(1);
    bus.speed = 4'd10;
    first_spawn = 0;
    for (int f = 1; f <= 22; f++) begin
      run_frame(1'b0);
      if (sp_spawn && first_spawn == 0) first_spawn = f;
    end
    check("post_reset_first_spawn_frame", first_spawn, 20);

    // Second instance: SCREEN_W=1000, MIN_GAP=0, LFSR fresh from the seed.
    // One step from 16'hACE1 gives 16'hE270: type 2'b10, thresh 0x70 = 112.
    bus2.run   = 1'b1;
    bus2.speed = 4'd10;
    spawns2      = 0;
    seen_full    = 1'b0;
    fourth_frame = 0;
    fourth_slot  = 7;
    for (int f = 1; f <= 102; f++) begin
      run_frame(1'b1);
      if (sp_act == 3'b111) seen_full = 1'b1;
      if (f == 1) begin
        check("i2_first_spawn", sp_spawn, 1);
        check("i2_first_active", sp_act, 3'b001);
        check("i2_first_x", sp_x[9:0], 1000);
        check("i2_first_type", sp_ty[1:0], 2'b10);
      end
      if (f == 12) check("i2_spawns_before_13", spawns2, 1);
      if (f == 13) begin
        check("i2_second_spawn_f13", sp_spawn, 1);
        check("i2_second_slot1_x", sp_x[19:10], 1000);
      end
      if (f == 102) check("i2_slot0_freed_in_move", mv_act[0], 0);
      if (sp_spawn) begin
        spawns2++;
        if (spawns2 == 4) begin
          fourth_frame = f;
          fourth_slot  = new_slot(1000);
        end
      end
    end
    check("i2_all_slots_full_seen", seen_full, 1);
    check("i2_fourth_spawn_frame", fourth_frame, 102);
    check("i2_fourth_spawn_slot", fourth_slot, 0);
    check("i2_spawn_total", spawns2, 4);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
